// File: rtl/osd_ctm_trace_decoder_pkg.sv
// osd_ctm_trace_decoder_pkg
// Shared definitions for CTM trace packets on the debug interconnect:
//   - dii_flit          : one interconnect flit (valid, last, 16-bit data)
//   - event type codes  : OSD_TYPE_EVENT, CTM_SUB_TRACE, CTM_SUB_OVERFLOW
//   - CTM_FLAG_*        : bit positions inside the 16-bit flags word
//   - ctm_trace_record  : parallel record layout reused by trace sinks
//   - ctm_dec_state_e   : decoder FSM state encoding
package osd_ctm_trace_decoder_pkg;

  localparam logic [1:0] OSD_TYPE_EVENT   = 2'b10;
  localparam logic [3:0] CTM_SUB_TRACE    = 4'h0;
  localparam logic [3:0] CTM_SUB_OVERFLOW = 4'h5;

  localparam int CTM_FLAG_JAL      = 0;
  localparam int CTM_FLAG_JALR     = 1;
  localparam int CTM_FLAG_BRANCH   = 2;
  localparam int CTM_FLAG_LOAD     = 3;
  localparam int CTM_FLAG_STORE    = 4;
  localparam int CTM_FLAG_TRAP     = 5;
  localparam int CTM_FLAG_XCPT     = 6;
  localparam int CTM_FLAG_MEM      = 7;
  localparam int CTM_FLAG_CSR      = 8;
  localparam int CTM_FLAG_BR_TAKEN = 9;
  localparam int CTM_FLAG_PRV_LO   = 10;
  localparam int CTM_FLAG_PRV_HI   = 11;

  // Bits of the flags word above PRV carry no meaning and are delivered as 0.
  localparam logic [15:0] CTM_FLAG_MASK = 16'h0FFF;

  localparam int CTM_MAX_ADDR_WIDTH = 64;
  localparam int CTM_TIME_WIDTH     = 32;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  // Sized for the widest address option; 32-bit sinks zero-extend pc/npc.
  typedef struct packed {
    logic [15:0]                   src;
    logic                          overflow;
    logic [15:0]                   lost;
    logic [CTM_TIME_WIDTH-1:0]     timestamp;
    logic [CTM_MAX_ADDR_WIDTH-1:0] npc;
    logic [CTM_MAX_ADDR_WIDTH-1:0] pc;
    logic [15:0]                   flags;
  } ctm_trace_record;

  typedef enum logic [2:0] {
    ST_DEST,
    ST_SRC,
    ST_TYPE,
    ST_PAYLOAD,
    ST_HOLD,
    ST_DROP
  } ctm_dec_state_e;

  // hdr = flit2[15:10] = {TYPE, TYPE_SUB}
  function automatic logic ctm_type_legal(input logic [5:0] hdr);
    return (hdr[5:4] == OSD_TYPE_EVENT) &&
           ((hdr[3:0] == CTM_SUB_TRACE) || (hdr[3:0] == CTM_SUB_OVERFLOW));
  endfunction

endpackage

// File: rtl/osd_ctm_trace_decoder.sv
// osd_ctm_trace_decoder
// Reassembles CTM event packets arriving as DII flits into one parallel
// trace record per packet, handed to a trace sink over valid/ready.
// Overflow packets become records with ev_overflow set; packets for other
// ids are swallowed silently; malformed packets give a 1-cycle err_pkt_o.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   id_i                own DII address
//   debug_in_i          incoming flit; accepted when valid && debug_in_ready_o
//   debug_in_ready_o    low only while a record waits for the sink
//   ev_valid_o/ready_i  record handshake
//   ev_src_o            source id of the CTM
//   ev_overflow_o       record is an overflow notice (ev_lost_o valid)
//   ev_lost_o           lost event count
//   ev_time_o           timestamp
//   ev_npc_o, ev_pc_o   next/jump target PC, retiring PC
//   ev_flags_o          event flags, [15:12] forced to 0
//   err_pkt_o           pulse one cycle after a malformed/unknown packet flit
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_DEST    | waiting for destination flit of a new packet
// ST_SRC     | waiting for source id flit
// ST_TYPE    | waiting for type/subtype flit
// ST_PAYLOAD | collecting payload flits into the record shifter
// ST_HOLD    | record presented, waiting for ev_ready_i
// ST_DROP    | discarding flits up to and including last
module osd_ctm_trace_decoder
  import osd_ctm_trace_decoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIME_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [15:0]           id_i,
  input  dii_flit               debug_in_i,
  output logic                  debug_in_ready_o,
  output logic                  ev_valid_o,
  input  logic                  ev_ready_i,
  output logic [15:0]           ev_src_o,
  output logic                  ev_overflow_o,
  output logic [15:0]           ev_lost_o,
  output logic [TIME_WIDTH-1:0] ev_time_o,
  output logic [ADDR_WIDTH-1:0] ev_npc_o,
  output logic [ADDR_WIDTH-1:0] ev_pc_o,
  output logic [15:0]           ev_flags_o,
  output logic                  err_pkt_o
);

  localparam int NA  = ADDR_WIDTH / 16;
  localparam int LEN = 2 * NA + 3;
  // Everything except the final flags flit is staged in the shifter; flags
  // are taken straight from the completing flit.
  localparam int SW  = TIME_WIDTH + 2 * ADDR_WIDTH;
  localparam logic [3:0] LEN_TRACE = 4'(LEN);

  ctm_dec_state_e  state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     src_q, src_d;
  logic [SW-1:0]   shreg_q, shreg_d;
  logic            ev_valid_q, ev_valid_d;
  logic            err_q, err_d;
  logic            load_trace, load_ovf;
  logic            accept, cnt_done;

  logic [15:0]           ev_src_q, ev_lost_q, ev_flags_q;
  logic                  ev_overflow_q;
  logic [TIME_WIDTH-1:0] ev_time_q;
  logic [ADDR_WIDTH-1:0] ev_npc_q, ev_pc_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    src_d      = src_q;
    shreg_d    = shreg_q;
    ev_valid_d = ev_valid_q;
    err_d      = 1'b0;
    load_trace = 1'b0;
    load_ovf   = 1'b0;
    accept     = debug_in_i.valid && (state_q != ST_HOLD);
    cnt_done   = ((cnt_q + 4'd1) == (ovf_q ? 4'd1 : LEN_TRACE));

    case (state_q)
      ST_DEST: begin
        // A lone dest flit with last set is a complete (empty) packet.
        if (accept && !debug_in_i.last)
          state_d = (debug_in_i.data == id_i) ? ST_SRC : ST_DROP;
      end
      ST_SRC: begin
        if (accept) begin
          src_d = debug_in_i.data;
          if (debug_in_i.last) begin
            err_d   = 1'b1;
            state_d = ST_DEST;
          end else begin
            state_d = ST_TYPE;
          end
        end
      end
      ST_TYPE: begin
        if (accept) begin
          if (ctm_type_legal(debug_in_i.data[15:10]) && !debug_in_i.last) begin
            state_d = ST_PAYLOAD;
            cnt_d   = 4'd0;
            ovf_d   = (debug_in_i.data[13:10] == CTM_SUB_OVERFLOW);
          end else begin
            err_d   = 1'b1;
            state_d = debug_in_i.last ? ST_DEST : ST_DROP;
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          shreg_d = {debug_in_i.data, shreg_q[SW-1:16]};
          cnt_d   = cnt_q + 4'd1;
          if (debug_in_i.last && cnt_done) begin
            load_trace = !ovf_q;
            load_ovf   = ovf_q;
            ev_valid_d = 1'b1;
            state_d    = ST_HOLD;
          end else if (debug_in_i.last) begin
            err_d   = 1'b1;
            state_d = ST_DEST;
          end else if (cnt_done) begin
            err_d   = 1'b1;
            state_d = ST_DROP;
          end
        end
      end
      ST_HOLD: begin
        if (ev_ready_i) begin
          ev_valid_d = 1'b0;
          state_d    = ST_DEST;
        end
      end
      ST_DROP: begin
        if (accept && debug_in_i.last)
          state_d = ST_DEST;
      end
      default: state_d = ST_DEST;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_DEST;
      cnt_q         <= 4'd0;
      ovf_q         <= 1'b0;
      src_q         <= 16'd0;
      shreg_q       <= '0;
      ev_valid_q    <= 1'b0;
      err_q         <= 1'b0;
      ev_src_q      <= 16'd0;
      ev_overflow_q <= 1'b0;
      ev_lost_q     <= 16'd0;
      ev_time_q     <= '0;
      ev_npc_q      <= '0;
      ev_pc_q       <= '0;
      ev_flags_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      src_q      <= src_d;
      shreg_q    <= shreg_d;
      ev_valid_q <= ev_valid_d;
      err_q      <= err_d;
      if (load_trace) begin
        ev_src_q      <= src_q;
        ev_overflow_q <= 1'b0;
        ev_lost_q     <= 16'd0;
        ev_time_q     <= shreg_q[TIME_WIDTH-1:0];
        ev_npc_q      <= shreg_q[TIME_WIDTH +: ADDR_WIDTH];
        ev_pc_q       <= shreg_q[TIME_WIDTH + ADDR_WIDTH +: ADDR_WIDTH];
        ev_flags_q    <= debug_in_i.data & CTM_FLAG_MASK;
      end else if (load_ovf) begin
        ev_src_q      <= src_q;
        ev_overflow_q <= 1'b1;
        ev_lost_q     <= debug_in_i.data;
        ev_time_q     <= '0;
        ev_npc_q      <= '0;
        ev_pc_q       <= '0;
        ev_flags_q    <= 16'd0;
      end
    end
  end

  assign debug_in_ready_o = (state_q != ST_HOLD);
  assign ev_valid_o       = ev_valid_q;
  assign err_pkt_o        = err_q;
  assign ev_src_o         = ev_src_q;
  assign ev_overflow_o    = ev_overflow_q;
  assign ev_lost_o        = ev_lost_q;
  assign ev_time_o        = ev_time_q;
  assign ev_npc_o         = ev_npc_q;
  assign ev_pc_o          = ev_pc_q;
  assign ev_flags_o       = ev_flags_q;

endmodule

// File: tb/tb_osd_ctm_trace_decoder.sv
`timescale 1ns/1ps
module tb_osd_ctm_trace_decoder;
  import osd_ctm_trace_decoder_pkg::*;

  localparam logic [15:0] MY_ID = 16'h0010;

  typedef struct packed {
    logic [15:0] src;
    logic        ovf;
    logic [15:0] lost;
    logic [31:0] tim;
    logic [63:0] npc;
    logic [63:0] pc;
    logic [15:0] flags;
  } rec_t;

  logic    clk = 1'b0;
  logic    rst;
  dii_flit din0, din1;
  logic    ev_ready;

  logic        rdy0, v0, ovf0, err0;
  logic [15:0] src0, lost0, flags0;
  logic [31:0] tim0, npc0, pc0;
  logic        rdy1, v1, ovf1, err1;
  logic [15:0] src1, lost1, flags1;
  logic [31:0] tim1;
  logic [63:0] npc1, pc1;

  int n_assert = 0;
  int n_fail   = 0;
  int rdy_mode = 1;
  int err_obs  = 0;
  int err_exp  = 0;
  rec_t exp_q[$];
  rec_t obs_q[$];
  logic [15:0] pkt[$];

  always #5 clk = ~clk;

  osd_ctm_trace_decoder #(.ADDR_WIDTH(32), .TIME_WIDTH(32)) dut0 (
    .clk_i(clk), .rst_i(rst), .id_i(MY_ID), .debug_in_i(din0),
    .debug_in_ready_o(rdy0), .ev_valid_o(v0), .ev_ready_i(ev_ready),
    .ev_src_o(src0), .ev_overflow_o(ovf0), .ev_lost_o(lost0),
    .ev_time_o(tim0), .ev_npc_o(npc0), .ev_pc_o(pc0),
    .ev_flags_o(flags0), .err_pkt_o(err0)
  );

  osd_ctm_trace_decoder #(.ADDR_WIDTH(64), .TIME_WIDTH(32)) dut1 (
    .clk_i(clk), .rst_i(rst), .id_i(MY_ID), .debug_in_i(din1),
    .debug_in_ready_o(rdy1), .ev_valid_o(v1), .ev_ready_i(ev_ready),
    .ev_src_o(src1), .ev_overflow_o(ovf1), .ev_lost_o(lost1),
    .ev_time_o(tim1), .ev_npc_o(npc1), .ev_pc_o(pc1),
    .ev_flags_o(flags1), .err_pkt_o(err1)
  );

  // Sink side: ev_ready changes just after the rising edge.
  initial begin
    ev_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ev_ready = 1'b0;
        1:       ev_ready = 1'b1;
        default: ev_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Collect handshaken records and error pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (v0 && ev_ready)
        obs_q.push_back({src0, ovf0, lost0, tim0, 32'h0, npc0, 32'h0, pc0, flags0});
      if (v1 && ev_ready)
        obs_q.push_back({src1, ovf1, lost1, tim1, npc1, pc1, flags1});
      if (err0) err_obs++;
      if (err1) err_obs++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

  function automatic rec_t trace_rec(input logic [15:0] s, input logic [31:0] t,
                                     input logic [63:0] n, input logic [63:0] p,
                                     input logic [15:0] f);
    return {s, 1'b0, 16'h0, t, n, p, f & 16'h0FFF};
  endfunction

  function automatic rec_t ovf_rec(input logic [15:0] s, input logic [15:0] l);
    return {s, 1'b1, l, 32'h0, 64'h0, 64'h0, 16'h0};
  endfunction

  // Well-formed trace packet: dest, src, type, then time/npc/pc LS flit first, flags.
  task automatic build_trace(input int na, input logic [15:0] dest, input logic [15:0] s,
                             input logic [31:0] t, input logic [63:0] n,
                             input logic [63:0] p, input logic [15:0] f);
    pkt.delete();
    pkt.push_back(dest);
    pkt.push_back(s);
    pkt.push_back({2'b10, 4'h0, 10'h0});
    pkt.push_back(t[15:0]);
    pkt.push_back(t[31:16]);
    for (int k = 0; k < na; k++) pkt.push_back(n[16*k +: 16]);
    for (int k = 0; k < na; k++) pkt.push_back(p[16*k +: 16]);
    pkt.push_back(f);
  endtask

  task automatic build_ovf(input logic [15:0] s, input logic [15:0] l);
    pkt.delete();
    pkt.push_back(MY_ID);
    pkt.push_back(s);
    pkt.push_back({2'b10, 4'h5, 10'h0});
    pkt.push_back(l);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_flit(input int sel, input logic [15:0] d, input logic lst);
    int tries;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    if (sel == 0) din0 = '{valid: 1'b1, last: lst, data: d};
    else          din1 = '{valid: 1'b1, last: lst, data: d};
    tries = 0;
    while (((sel == 0) ? !rdy0 : !rdy1) && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 200) begin
      n_assert++;
      n_fail++;
      $display("FAIL flit_accept_timeout: ready low for %0d cycles, need 1", tries);
    end
    @(negedge clk);
    din0.valid = 1'b0;
    din1.valid = 1'b0;
  endtask

  task automatic send_pkt(input int sel);
    for (int i = 0; i < pkt.size(); i++)
      send_flit(sel, pkt[i], (i == pkt.size() - 1));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (t < 400 && (obs_q.size() < exp_q.size() || v0 || v1)) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    err_obs = 0;
    err_exp = 0;
  endtask

  task automatic test_reset();
    din0 = '0;
    din1 = '0;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({v0, err0, src0, ovf0, lost0, tim0, npc0, pc0, flags0} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs32: got %h, need 0",
               {v0, err0, src0, ovf0, lost0, tim0, npc0, pc0, flags0});
    end
    n_assert++;
    if ({v1, err1, src1, ovf1, lost1, tim1, npc1, pc1, flags1} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs64: got %h, need 0",
               {v1, err1, src1, ovf1, lost1, tim1, npc1, pc1, flags1});
    end
    n_assert++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b%b, need 11", rdy0, rdy1);
    end
  endtask

  task automatic test_basic();
    rdy_mode = 1;
    clear_sb();
    build_trace(2, 16'h0010, 16'h0042, 32'h0000_1234, 64'h8000_0100, 64'h8000_00F0, 16'h0001);
    for (int i = 0; i < pkt.size() - 1; i++) send_flit(0, pkt[i], 1'b0);
    n_assert++;
    if (v0 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_valid_early: got %b, need 0", v0);
    end
    send_flit(0, pkt[pkt.size() - 1], 1'b1);
    n_assert++;
    if (v0 !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_valid_latency: got %b, need 1", v0);
    end
    n_assert++;
    if ({src0, ovf0, lost0, tim0, npc0, pc0, flags0} !==
        {16'h0042, 1'b0, 16'h0, 32'h0000_1234, 32'h8000_0100, 32'h8000_00F0, 16'h0001}) begin
      n_fail++;
      $display("FAIL basic_fields: got %h, need %h", {src0, ovf0, lost0, tim0, npc0, pc0, flags0},
               {16'h0042, 1'b0, 16'h0, 32'h0000_1234, 32'h8000_0100, 32'h8000_00F0, 16'h0001});
    end
    @(negedge clk);
    n_assert++;
    if (v0 !== 1'b0 || rdy0 !== 1'b1 || err_obs !== 0) begin
      n_fail++;
      $display("FAIL basic_release: valid=%b ready=%b errs=%0d, need 0 1 0", v0, rdy0, err_obs);
    end
  endtask

  task automatic test_backpressure();
    logic [175:0] snap;
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    build_trace(2, 16'h0010, 16'h0042, 32'h0000_1234, 64'h8000_0100, 64'h8000_00F0, 16'h0001);
    send_pkt(0);
    snap = {src0, ovf0, lost0, tim0, npc0, pc0, flags0};
    n_assert++;
    if (v0 !== 1'b1 || snap !==
        {16'h0042, 1'b0, 16'h0, 32'h0000_1234, 32'h8000_0100, 32'h8000_00F0, 16'h0001}) begin
      n_fail++;
      $display("FAIL bp_initial: valid=%b fields=%h, need 1 with basic record", v0, snap);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_assert++;
      if (v0 !== 1'b1 || rdy0 !== 1'b0 || {src0, ovf0, lost0, tim0, npc0, pc0, flags0} !== snap) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: valid=%b ready=%b fields=%h, need 1 0 %h", c, v0, rdy0,
                 {src0, ovf0, lost0, tim0, npc0, pc0, flags0}, snap);
      end
    end
    rdy_mode = 1;
    @(negedge clk);
    n_assert++;
    if (v0 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_before_release: valid=%b, need 1", v0);
    end
    @(negedge clk);
    n_assert++;
    if (v0 !== 1'b0 || rdy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b ready=%b, need 0 1", v0, rdy0);
    end
  endtask

  task automatic test_wrong_dest();
    logic [15:0] s;
    logic [31:0] t, n, p;
    logic [15:0] f;
    rdy_mode = 2;
    clear_sb();
    build_trace(2, 16'h0011, 16'h0099, $urandom, {32'h0, $urandom}, {32'h0, $urandom}, 16'hFFFF);
    void'(pkt.pop_back());
    send_pkt(0);
    s = 16'($urandom); t = $urandom; n = $urandom; p = $urandom; f = 16'($urandom);
    build_trace(2, MY_ID, s, t, {32'h0, n}, {32'h0, p}, f);
    exp_q.push_back(trace_rec(s, t, {32'h0, n}, {32'h0, p}, f));
    send_pkt(0);
    drain();
    n_assert++;
    if (obs_q.size() !== 1 || err_obs !== 0) begin
      n_fail++;
      $display("FAIL dest_filter: records=%0d errs=%0d, need 1 0", obs_q.size(), err_obs);
    end
    if (obs_q.size() > 0) begin
      n_assert++;
      if (obs_q[0] !== exp_q[0]) begin
        n_fail++;
        $display("FAIL dest_follow_rec: got %h, need %h", obs_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_overflow();
    rdy_mode = 1;
    clear_sb();
    build_ovf(16'h0042, 16'h0007);
    send_pkt(0);
    n_assert++;
    if (v0 !== 1'b1 || {src0, ovf0, lost0, tim0, npc0, pc0, flags0} !==
        {16'h0042, 1'b1, 16'h0007, 32'h0, 32'h0, 32'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL overflow_rec: valid=%b fields=%h, need 1 %h", v0,
               {src0, ovf0, lost0, tim0, npc0, pc0, flags0},
               {16'h0042, 1'b1, 16'h0007, 32'h0, 32'h0, 32'h0, 16'h0});
    end
    drain();
  endtask

  task automatic test_malformed();
    logic [15:0] s;
    logic [31:0] t, n, p;
    rdy_mode = 2;
    clear_sb();
    build_trace(2, MY_ID, 16'h0042, 32'h1, 64'h2, 64'h3, 16'h4);
    while (pkt.size() > 7) void'(pkt.pop_back());
    send_pkt(0);
    n_assert++;
    if (err0 !== 1'b1 || v0 !== 1'b0) begin
      n_fail++;
      $display("FAIL short_pulse: err=%b valid=%b, need 1 0", err0, v0);
    end
    build_trace(2, MY_ID, 16'h0042, 32'h5, 64'h6, 64'h7, 16'h8);
    pkt.push_back(16'hBEEF);
    send_pkt(0);
    s = 16'($urandom); t = $urandom; n = $urandom; p = $urandom;
    build_trace(2, MY_ID, s, t, {32'h0, n}, {32'h0, p}, 16'h0A5A);
    exp_q.push_back(trace_rec(s, t, {32'h0, n}, {32'h0, p}, 16'h0A5A));
    send_pkt(0);
    drain();
    n_assert++;
    if (err_obs !== 2 || obs_q.size() !== 1) begin
      n_fail++;
      $display("FAIL malformed_counts: errs=%0d records=%0d, need 2 1", err_obs, obs_q.size());
    end
    if (obs_q.size() > 0) begin
      n_assert++;
      if (obs_q[0] !== exp_q[0]) begin
        n_fail++;
        $display("FAIL malformed_follow_rec: got %h, need %h", obs_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_reset_midpacket();
    logic [15:0] s;
    logic [31:0] t;
    rdy_mode = 1;
    build_trace(2, MY_ID, 16'h1111, 32'hAAAA_5555, 64'h1234_5678, 64'h9ABC_DEF0, 16'h0FFF);
    for (int i = 0; i < 5; i++) send_flit(0, pkt[i], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_assert++;
    if ({v0, err0, src0, ovf0, lost0, tim0, npc0, pc0, flags0} !== '0 || rdy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_payload: outs=%h ready=%b, need 0 1",
               {v0, err0, src0, ovf0, lost0, tim0, npc0, pc0, flags0}, rdy0);
    end
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    send_pkt(0);
    n_assert++;
    if (v0 !== 1'b1 || src0 !== 16'h1111) begin
      n_fail++;
      $display("FAIL rst_pre_hold: valid=%b src=%h, need 1 1111", v0, src0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_assert++;
    if ({v0, err0, src0, ovf0, lost0, tim0, npc0, pc0, flags0} !== '0 || rdy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_hold: outs=%h ready=%b, need 0 1",
               {v0, err0, src0, ovf0, lost0, tim0, npc0, pc0, flags0}, rdy0);
    end
    rdy_mode = 2;
    clear_sb();
    s = 16'($urandom); t = $urandom;
    build_ovf(s, t[15:0]);
    exp_q.push_back(ovf_rec(s, t[15:0]));
    send_pkt(0);
    drain();
    n_assert++;
    if (obs_q.size() !== 1 || err_obs !== 0) begin
      n_fail++;
      $display("FAIL rst_recover_count: records=%0d errs=%0d, need 1 0", obs_q.size(), err_obs);
    end
    if (obs_q.size() > 0) begin
      n_assert++;
      if (obs_q[0] !== exp_q[0]) begin
        n_fail++;
        $display("FAIL rst_recover_rec: got %h, need %h", obs_q[0], exp_q[0]);
      end
    end
  endtask

  // Random packet mix; expectations come from what each packet was built to be.
  task automatic test_random(input int sel, input int npkt);
    int na, plen, kind, k;
    logic [15:0] s, f, l;
    logic [31:0] t;
    logic [63:0] n, p;
    logic [1:0]  ty;
    logic [3:0]  sub;
    na   = (sel == 0) ? 2 : 4;
    plen = 2 * na + 3;
    rdy_mode = 2;
    clear_sb();
    repeat (npkt) begin
      kind = $urandom_range(0, 8);
      s = 16'($urandom); f = 16'($urandom); l = 16'($urandom); t = $urandom;
      n = (na == 2) ? {32'h0, $urandom} : {$urandom, $urandom};
      p = (na == 2) ? {32'h0, $urandom} : {$urandom, $urandom};
      build_trace(na, MY_ID, s, t, n, p, f);
      case (kind)
        0, 1, 2: exp_q.push_back(trace_rec(s, t, n, p, f));
        3: begin
          build_ovf(s, l);
          if ($urandom_range(0, 1) == 1) begin
            pkt.push_back(16'($urandom));
            err_exp++;
          end else begin
            exp_q.push_back(ovf_rec(s, l));
          end
        end
        4: pkt[0] = MY_ID ^ (16'h1 << $urandom_range(0, 15));
        5: begin
          k = $urandom_range(0, plen - 1);
          while (pkt.size() > 3 + k) void'(pkt.pop_back());
          err_exp++;
        end
        6: begin
          repeat ($urandom_range(1, 3)) pkt.push_back(16'($urandom));
          err_exp++;
        end
        7: begin
          ty  = 2'($urandom_range(0, 3));
          sub = 4'($urandom_range(0, 15));
          if (ty == 2'b10 && (sub == 4'h0 || sub == 4'h5)) sub = 4'h9;
          pkt[2] = {ty, sub, 10'($urandom)};
          if ($urandom_range(0, 1) == 1) while (pkt.size() > 3) void'(pkt.pop_back());
          err_exp++;
        end
        default: begin
          if ($urandom_range(0, 1) == 1) begin
            while (pkt.size() > 2) void'(pkt.pop_back());
            err_exp++;
          end else begin
            while (pkt.size() > 1) void'(pkt.pop_back());
            pkt[0] = 16'($urandom);
          end
        end
      endcase
      send_pkt(sel);
    end
    drain();
    n_assert++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL rand%0d_count: got %0d records, need %0d", sel, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand%0d_rec%0d: got %h, need %h", sel, i, obs_q[i], exp_q[i]);
      end
    end
    n_assert++;
    if (err_obs !== err_exp) begin
      n_fail++;
      $display("FAIL rand%0d_errs: got %0d pulses, need %0d", sel, err_obs, err_exp);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrong_dest();
    test_overflow();
    test_malformed();
    test_reset_midpacket();
    test_random(0, 60);
    test_random(1, 40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
